// File: rtl/JZJCoreFTypes.sv
// Shared types and RV32I opcode constants for the JZJCoreF datapath and its control sequencer.
package JZJCoreFTypes;

    typedef enum logic [2:0] {
        FETCH,
        EXECUTE,
        MEM_WAIT,
        WRITEBACK,
        HALT
    } controlState_t;

    typedef enum logic {
        PC_SEQ       = 1'b0,
        PC_BRANCHALU = 1'b1
    } pcSource_t;

    typedef enum logic {
        LUI   = 1'b0,
        AUIPC = 1'b1
    } immediateFormerMode_t;

    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic alu;
        logic aluImm;
        logic lui;
        logic auipc;
        logic jump;
        logic branch;
        logic load;
        logic store;
        logic fence;
        logic system;
        logic illegal;
    } opcodeClass_t;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode/funct3 decode into a one-hot instruction class.
module opcode_classifier
    import JZJCoreFTypes::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output opcodeClass_t opClass
);

    always_comb begin
        opClass = '0;
        case (opcode)
            OPCODE_OP:       opClass.alu    = 1'b1;
            OPCODE_OP_IMM:   opClass.aluImm = 1'b1;
            OPCODE_LUI:      opClass.lui    = 1'b1;
            OPCODE_AUIPC:    opClass.auipc  = 1'b1;
            OPCODE_JAL:      opClass.jump   = 1'b1;
            OPCODE_JALR: begin
                if (funct3 == 3'b000) opClass.jump    = 1'b1;
                else                  opClass.illegal = 1'b1;
            end
            OPCODE_BRANCH:   opClass.branch = 1'b1;
            OPCODE_STORE:    opClass.store  = 1'b1;
            OPCODE_LOAD:     opClass.load   = 1'b1;
            OPCODE_MISC_MEM: opClass.fence  = 1'b1;
            OPCODE_SYSTEM:   opClass.system = 1'b1;
            default:         opClass.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control FSM: fetch, execute, memory wait, writeback and halt, with a retire counter.
module control_sequencer
    import JZJCoreFTypes::*;
#(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 haltRequest,
    input  logic                 resume,
    output logic                 instructionFetchEnable,
    output logic                 pcWriteEnable,
    output pcSource_t            pcSource,
    output logic                 rdWriteEnable,
    output logic                 memoryOutputEnable,
    output logic                 aluOutputEnable,
    output logic                 immediateFormerOutputEnable,
    output logic                 branchALUOutputEnable,
    output logic                 memoryWriteEnable,
    output logic                 opImm,
    output immediateFormerMode_t immediateFormerMode,
    output logic                 halted,
    output logic                 illegalInstruction,
    output logic [31:0]          instructionsRetired
);

    localparam logic [3:0] WAIT_INIT = (MEM_LATENCY == 0) ? 4'd0 : 4'(MEM_LATENCY - 1);

    controlState_t state;
    logic [3:0]    waitCount;
    logic [31:0]   retiredCount;
    logic          illegalFlag;
    logic          skipHalt;
    logic          haltNow;
    opcodeClass_t  opClass;

    opcode_classifier classifier (
        .opcode  (opcode),
        .funct3  (funct3),
        .opClass (opClass)
    );

    // The first FETCH after a resume ignores haltRequest so one instruction always runs.
    assign haltNow = (state == FETCH) && haltRequest && !skipHalt;

    always_comb begin
        instructionFetchEnable      = 1'b0;
        pcWriteEnable               = 1'b0;
        pcSource                    = PC_SEQ;
        rdWriteEnable               = 1'b0;
        memoryOutputEnable          = 1'b0;
        aluOutputEnable             = 1'b0;
        immediateFormerOutputEnable = 1'b0;
        branchALUOutputEnable       = 1'b0;
        memoryWriteEnable           = 1'b0;
        opImm                       = 1'b0;
        immediateFormerMode         = LUI;
        halted                      = 1'b0;
        illegalInstruction          = 1'b0;
        instructionsRetired         = 32'd0;
        if (!reset) begin
            illegalInstruction  = illegalFlag;
            instructionsRetired = retiredCount;
            case (state)
                FETCH: instructionFetchEnable = !haltNow;
                EXECUTE: begin
                    if (opClass.alu || opClass.aluImm) begin
                        aluOutputEnable = 1'b1;
                        rdWriteEnable   = 1'b1;
                        pcWriteEnable   = 1'b1;
                        opImm           = opClass.aluImm;
                    end else if (opClass.lui || opClass.auipc) begin
                        immediateFormerOutputEnable = 1'b1;
                        immediateFormerMode         = opClass.auipc ? AUIPC : LUI;
                        rdWriteEnable               = 1'b1;
                        pcWriteEnable               = 1'b1;
                    end else if (opClass.jump) begin
                        branchALUOutputEnable = 1'b1;
                        rdWriteEnable         = 1'b1;
                        pcWriteEnable         = 1'b1;
                        pcSource              = PC_BRANCHALU;
                    end else if (opClass.branch) begin
                        pcWriteEnable = 1'b1;
                        pcSource      = PC_BRANCHALU;
                    end else if (opClass.store) begin
                        memoryWriteEnable = 1'b1;
                        pcWriteEnable     = 1'b1;
                    end else if (opClass.fence || opClass.system) begin
                        pcWriteEnable = 1'b1;
                    end
                end
                WRITEBACK: begin
                    memoryOutputEnable = 1'b1;
                    rdWriteEnable      = 1'b1;
                    pcWriteEnable      = 1'b1;
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            waitCount    <= 4'd0;
            retiredCount <= 32'd0;
            illegalFlag  <= 1'b0;
            skipHalt     <= 1'b0;
        end else begin
            if (pcWriteEnable) retiredCount <= retiredCount + 32'd1;
            case (state)
                FETCH: begin
                    if (haltNow) begin
                        state <= HALT;
                    end else begin
                        state    <= EXECUTE;
                        skipHalt <= 1'b0;
                    end
                end
                EXECUTE: begin
                    if (opClass.load) begin
                        if (MEM_LATENCY == 0) begin
                            state <= WRITEBACK;
                        end else begin
                            state     <= MEM_WAIT;
                            waitCount <= WAIT_INIT;
                        end
                    end else if (opClass.system) begin
                        state <= HALT;
                    end else if (opClass.illegal) begin
                        illegalFlag <= 1'b1;
                        state       <= HALT;
                    end else begin
                        state <= FETCH;
                    end
                end
                MEM_WAIT: begin
                    if (waitCount == 4'd0) state <= WRITEBACK;
                    else                   waitCount <= waitCount - 4'd1;
                end
                WRITEBACK: state <= FETCH;
                HALT: begin
                    if (resume) begin
                        illegalFlag <= 1'b0;
                        skipHalt    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized self-checking bench for control_sequencer against an instruction-level timing model.
module tb_control_sequencer;
    import JZJCoreFTypes::*;

    localparam logic [12:0] B_FETCH  = 13'h1000;
    localparam logic [12:0] B_PCWE   = 13'h0800;
    localparam logic [12:0] B_PCBR   = 13'h0400;
    localparam logic [12:0] B_RDWE   = 13'h0200;
    localparam logic [12:0] B_MEMOE  = 13'h0100;
    localparam logic [12:0] B_ALUOE  = 13'h0080;
    localparam logic [12:0] B_IMMOE  = 13'h0040;
    localparam logic [12:0] B_BROE   = 13'h0020;
    localparam logic [12:0] B_MEMWE  = 13'h0010;
    localparam logic [12:0] B_OPIMM  = 13'h0008;
    localparam logic [12:0] B_AUIPC  = 13'h0004;
    localparam logic [12:0] B_HALTED = 13'h0002;
    localparam logic [12:0] B_ILLEG  = 13'h0001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       haltRequest = 1'b0;
    logic       resume = 1'b0;
    int         sel = 0;

    logic                 rstK[3];
    logic                 fetchEn[3], pcWe[3], rdWe[3], memOe[3], aluOe[3], immOe[3];
    logic                 brOe[3], memWe[3], opImmO[3], haltedO[3], illegalO[3];
    pcSource_t            pcSrc[3];
    immediateFormerMode_t immMode[3];
    logic [31:0]          retired[3];

    int          tests = 0;
    int          failures = 0;
    int          lat = 1;
    logic [31:0] modelCount = 32'd0;
    bit          modelIllegal = 0;
    bit          modelHalted = 0;
    bit          skip = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 0);
        assign rstK[g] = reset | (sel != g);
        control_sequencer #(.MEM_LATENCY(LAT)) u_dut (
            .clock                       (clock),
            .reset                       (rstK[g]),
            .opcode                      (opcode),
            .funct3                      (funct3),
            .haltRequest                 (haltRequest),
            .resume                      (resume),
            .instructionFetchEnable      (fetchEn[g]),
            .pcWriteEnable               (pcWe[g]),
            .pcSource                    (pcSrc[g]),
            .rdWriteEnable               (rdWe[g]),
            .memoryOutputEnable          (memOe[g]),
            .aluOutputEnable             (aluOe[g]),
            .immediateFormerOutputEnable (immOe[g]),
            .branchALUOutputEnable       (brOe[g]),
            .memoryWriteEnable           (memWe[g]),
            .opImm                       (opImmO[g]),
            .immediateFormerMode         (immMode[g]),
            .halted                      (haltedO[g]),
            .illegalInstruction          (illegalO[g]),
            .instructionsRetired         (retired[g])
        );
    end

    task automatic checkEq(input string tag, input logic [31:0] actual,
                           input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s (lat=%0d t=%0t): got %h expected %h", tag, lat, $time, actual,
                     expected);
        end
    endtask

    function automatic logic [12:0] obsVec();
        return {fetchEn[sel], pcWe[sel], pcSrc[sel] == PC_BRANCHALU, rdWe[sel], memOe[sel],
                aluOe[sel], immOe[sel], brOe[sel], memWe[sel], opImmO[sel],
                immMode[sel] == AUIPC, haltedO[sel], illegalO[sel]};
    endfunction

    // Called just after a negedge: check this cycle's outputs, then advance one cycle.
    task automatic tick(input logic [12:0] e, input string tag);
        int  n;
        logic ok;
        #1;
        checkEq(tag, {19'd0, obsVec()}, {19'd0, e});
        checkEq({tag, ".count"}, retired[sel], modelCount);
        n  = $countones({memOe[sel], aluOe[sel], immOe[sel], brOe[sel]});
        ok = rdWe[sel] ? (n == 1) : (n <= 1);
        checkEq({tag, ".rdOneHot"}, {31'd0, ok}, 32'd1);
        @(negedge clock);
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        haltRequest = 1'b0;
        resume = 1'b0;
        modelCount = 32'd0;
        for (int i = 0; i < n; i++) tick(13'h0, "reset");
        reset = 1'b0;
        modelIllegal = 0;
        modelHalted = 0;
        skip = 0;
    endtask

    task automatic selectDut(input int k);
        reset = 1'b1;
        sel = k;
        lat = (k == 0) ? 1 : ((k == 1) ? 3 : 0);
        doReset(2);
    endtask

    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic hreqFetch,
                            input logic hreqLater);
        logic [12:0] e;
        bit toHalt, isLoad, bad;
        opcode = op;
        funct3 = f3;
        haltRequest = hreqFetch;
        resume = 1'b0;
        if (hreqFetch && !skip) begin
            tick(13'h0, "fetchHalt");
            modelHalted = 1;
            return;
        end
        skip = 0;
        tick(B_FETCH, "fetch");
        haltRequest = hreqLater;
        e = 13'h0;
        toHalt = 0;
        isLoad = 0;
        bad = 0;
        case (op)
            7'b0110011: e = B_ALUOE | B_RDWE | B_PCWE;
            7'b0010011: e = B_ALUOE | B_RDWE | B_PCWE | B_OPIMM;
            7'b0110111: e = B_IMMOE | B_RDWE | B_PCWE;
            7'b0010111: e = B_IMMOE | B_RDWE | B_PCWE | B_AUIPC;
            7'b1101111: e = B_BROE | B_RDWE | B_PCWE | B_PCBR;
            7'b1100111: begin
                if (f3 == 3'b000) e = B_BROE | B_RDWE | B_PCWE | B_PCBR;
                else              bad = 1;
            end
            7'b1100011: e = B_PCWE | B_PCBR;
            7'b0100011: e = B_MEMWE | B_PCWE;
            7'b0001111: e = B_PCWE;
            7'b1110011: begin e = B_PCWE; toHalt = 1; end
            7'b0000011: isLoad = 1;
            default:    bad = 1;
        endcase
        if (isLoad) begin
            tick(13'h0, "loadExec");
            for (int i = 0; i < lat; i++) tick(13'h0, "memWait");
            tick(B_MEMOE | B_RDWE | B_PCWE, "writeback");
            modelCount = modelCount + 32'd1;
        end else if (bad) begin
            tick(13'h0, "illegalExec");
            modelIllegal = 1;
            modelHalted = 1;
        end else begin
            tick(e, "exec");
            modelCount = modelCount + 32'd1;
            modelHalted = toHalt;
        end
    endtask

    task automatic haltCycles(input int n, input logic hreq);
        logic [12:0] e;
        resume = 1'b0;
        e = B_HALTED | (modelIllegal ? B_ILLEG : 13'h0);
        for (int i = 0; i < n; i++) tick(e, "halt");
        resume = 1'b1;
        haltRequest = hreq;
        tick(e, "haltResume");
        resume = 1'b0;
        modelIllegal = 0;
        modelHalted = 0;
        skip = 1;
    endtask

    task automatic randomRun(input int n);
        logic [6:0] ops[11];
        logic [6:0] op;
        logic [2:0] f3;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                7'b1100011, 7'b0100011, 7'b0000011, 7'b0001111, 7'b1110011};
        for (int i = 0; i < n; i++) begin
            if (modelHalted) begin
                haltCycles(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end else begin
                if ($urandom_range(0, 11) == 0) op = 7'($urandom_range(0, 127));
                else                            op = ops[$urandom_range(0, 10)];
                f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
                runInstr(op, f3, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clock);
        selectDut(0);
        runInstr(7'b0010011, 3'd0, 1'b0, 1'b0);     // ADDI
        runInstr(7'b0000011, 3'd2, 1'b0, 1'b0);     // LOAD
        runInstr(7'b1111111, 3'd0, 1'b0, 1'b0);     // illegal
        haltCycles(2, 1'b0);
        runInstr(7'b0100011, 3'd2, 1'b0, 1'b1);     // STORE, haltRequest raised in EXECUTE
        runInstr(7'b0110011, 3'd0, 1'b1, 1'b1);     // halts from FETCH
        haltCycles(1, 1'b1);                        // resume together with haltRequest
        runInstr(7'b0110011, 3'd0, 1'b1, 1'b0);     // still runs once
        force g_dut[0].u_dut.retiredCount = 32'hFFFF_FFFF;
        #1;
        release g_dut[0].u_dut.retiredCount;
        modelCount = 32'hFFFF_FFFF;
        runInstr(7'b1101111, 3'd0, 1'b0, 1'b0);     // JAL wraps the counter
        runInstr(7'b1100111, 3'd1, 1'b0, 1'b0);     // JALR with bad funct3
        haltCycles(0, 1'b0);
        runInstr(7'b1110011, 3'd0, 1'b0, 1'b0);     // SYSTEM
        haltCycles(1, 1'b0);
        randomRun(150);

        selectDut(1);
        runInstr(7'b0000011, 3'd0, 1'b0, 1'b0);
        opcode = 7'b0000011;
        haltRequest = 1'b0;
        tick(B_FETCH, "rstFetch");
        tick(13'h0, "rstExec");
        tick(13'h0, "rstMemWait");
        doReset(3);
        runInstr(7'b0110011, 3'd0, 1'b0, 1'b0);
        randomRun(100);

        selectDut(2);
        runInstr(7'b0000011, 3'd0, 1'b0, 1'b0);
        randomRun(100);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
